// File: rtl/cmp4_pkg.sv
// Shared types and constants for the cmp4 comparator sweep driver.
package cmp4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned ERR_W   = 8;
  localparam int unsigned ERR_MAX = 255;
  localparam int unsigned TMR_W   = 4;

endpackage

// File: rtl/cmp4_settle_timer.sv
// Down-counter that holds the operands for SETTLE cycles before sampling.
module cmp4_settle_timer
  import cmp4_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expired_c
);

  logic [TMR_W-1:0] cnt;

  // Loaded with SETTLE-1 so DRIVE lasts exactly SETTLE cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TMR_W'(SETTLE - 1);
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - TMR_W'(1);
    end
  end

  assign expired_c = (cnt == '0);

endmodule

// File: rtl/cmp4_driver.sv
// Exhaustive sweep driver/checker for a WIDTH-bit comparator.
// Optional first-failure capture enabled by CMP4_DRIVER_FIRST_FAIL_EN.
module cmp4_driver
  import cmp4_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned SETTLE   = 1,
  parameter int unsigned POLARITY = 0
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               start,
  output logic               busy,
  output logic [WIDTH-1:0]   I0,
  output logic [WIDTH-1:0]   I1,
  input  logic               O,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [2*WIDTH-1:0] fail_vec
);

  localparam int unsigned CW = 2 * WIDTH;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             tmr_load_c;
  logic             tmr_expired_c;
  logic             accept_c;
  logic             last_c;
  logic             mismatch_c;
  logic [ERR_W-1:0] err_nx_c;

  cmp4_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk       (CLK),
    .rst_n     (RESETN),
    .load      (tmr_load_c),
    .run       (state == DRIVE),
    .expired_c (tmr_expired_c)
  );

  assign I0 = cnt[WIDTH-1:0];
  assign I1 = cnt[CW-1:WIDTH];

  assign accept_c   = (state == IDLE) && start;
  assign last_c     = &cnt;
  assign mismatch_c = (state == SAMPLE) && (O != ((I0 != I1) ^ 1'(POLARITY)));
  assign err_nx_c   = (mismatch_c && (err_count != ERR_W'(ERR_MAX))) ?
                      err_count + ERR_W'(1) : err_count;

  // Next-state logic; the timer reloads on every entry into DRIVE.
  always_comb begin
    state_nx   = state;
    tmr_load_c = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = DRIVE;
          tmr_load_c = 1'b1;
        end
      end
      DRIVE: begin
        if (tmr_expired_c) state_nx = SAMPLE;
      end
      SAMPLE: begin
        if (last_c) begin
          state_nx = DONE;
        end else begin
          state_nx   = DRIVE;
          tmr_load_c = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      cnt       <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == DRIVE) || (state_nx == SAMPLE);
      done  <= (state_nx == DONE);
      if (accept_c) begin
        cnt       <= '0;
        err_count <= '0;
        pass      <= 1'b0;
      end else if (state == SAMPLE) begin
        cnt       <= cnt + CW'(1);
        err_count <= err_nx_c;
        if (last_c) pass <= (err_nx_c == '0);
      end
    end
  end

`ifdef CMP4_DRIVER_FIRST_FAIL_EN
  logic fail_seen;

  // Keep only the first mismatching {I1,I0} of each sweep.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      fail_vec  <= '0;
      fail_seen <= 1'b0;
    end else if (accept_c) begin
      fail_vec  <= '0;
      fail_seen <= 1'b0;
    end else if (mismatch_c && !fail_seen) begin
      fail_vec  <= cnt;
      fail_seen <= 1'b1;
    end
  end
`else
  assign fail_vec = '0;
`endif

endmodule
